// File: rtl/writeback_arbiter_pkg.sv
// writeback_arbiter_pkg: shared widths, reset level and writeback entry type
package writeback_arbiter_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int WB_FIFO_DEPTH = 2;
  localparam logic [REG_ADDR_WIDTH-1:0] ZERO_REG = '0;
  localparam logic RESET = 1'b1;
  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] w_data;
  } writeback_entry_t;
endpackage

// File: rtl/wb_result_fifo.sv
// wb_result_fifo: in-order circular buffer for long-latency results
module wb_result_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  import writeback_arbiter_pkg::*;
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[head];
  always_ff @(posedge clk) begin
    if (rst == RESET) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[tail] <= din;
        tail <= tail == LAST ? '0 : tail + 1'b1;
      end
      if (pop) head <= head == LAST ? '0 : head + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: merges ALU and queued LSU results into one registered regfile write port
module writeback_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      aluValid,
  input  logic [REG_ADDR_WIDTH-1:0] aluRdAddr,
  input  logic [DATA_WIDTH-1:0]     aluData,
  input  logic                      lsuValid,
  output logic                      lsuReady,
  input  logic [REG_ADDR_WIDTH-1:0] lsuRdAddr,
  input  logic [DATA_WIDTH-1:0]     lsuData,
  output logic                      stallAlu,
  output logic                      wEnable,
  output logic [REG_ADDR_WIDTH-1:0] rdAddr,
  output logic [DATA_WIDTH-1:0]     wData,
  output logic                      protoErr
);
  import writeback_arbiter_pkg::*;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_cnt;
  logic full, empty, push, pop, sel_alu;
  logic [REG_ADDR_WIDTH-1:0] head_rd;
  logic [DATA_WIDTH-1:0] head_data;
  assign stallAlu = starve_cnt == SW'(STARVE_LIMIT);
  assign lsuReady = (rst != RESET) && !full;
  assign sel_alu = aluValid && !stallAlu;
  assign push = lsuValid && lsuReady;
  assign pop = (rst != RESET) && !sel_alu && !empty;
  wb_result_fifo #(.WIDTH(REG_ADDR_WIDTH + DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .din({lsuRdAddr, lsuData}),
    .dout({head_rd, head_data}),
    .full(full),
    .empty(empty)
  );
  // a non-empty FIFO that does not pop means the ALU won, so the counter only climbs then
  always_ff @(posedge clk) begin
    if (rst == RESET) begin
      starve_cnt <= '0;
      wEnable <= 1'b0;
      rdAddr <= '0;
      wData <= '0;
      protoErr <= 1'b0;
    end else begin
      starve_cnt <= (pop || empty) ? '0 : starve_cnt + 1'b1;
      wEnable <= sel_alu ? aluRdAddr != '0 : pop && head_rd != '0;
      if (sel_alu) {rdAddr, wData} <= {aluRdAddr, aluData};
      else if (pop) {rdAddr, wData} <= {head_rd, head_data};
      if (aluValid && stallAlu) protoErr <= 1'b1;
    end
  end
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: directed stimulus with a queue-based reference model checked every cycle
module tb_writeback_arbiter;
  import writeback_arbiter_pkg::*;
  logic clk = 0, rst = 1;
  logic alu_valid = 0, lsu_valid = 0;
  logic [4:0] alu_rd = 0, lsu_rd = 0;
  logic [31:0] alu_data = 0, lsu_data = 0;
  logic lsuReady, stallAlu, wEnable, protoErr;
  logic [4:0] rdAddr;
  logic [31:0] wData;
  int compared = 0, mismatched = 0;
  writeback_arbiter dut (
    .clk(clk), .rst(rst),
    .aluValid(alu_valid), .aluRdAddr(alu_rd), .aluData(alu_data),
    .lsuValid(lsu_valid), .lsuReady(lsuReady), .lsuRdAddr(lsu_rd), .lsuData(lsu_data),
    .stallAlu(stallAlu), .wEnable(wEnable), .rdAddr(rdAddr), .wData(wData), .protoErr(protoErr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  writeback_entry_t q[$];
  int m_starve = 0;
  logic m_we = 0, m_perr = 0, armed = 0;
  logic [4:0] m_rd = 0;
  logic [31:0] m_wd = 0;
  // reference: ALU wins unless the queue has waited four ALU wins in a row
  always @(posedge clk) begin
    logic stall, ready, had;
    writeback_entry_t e;
    if (rst) begin
      q.delete();
      m_starve = 0;
      m_we = 0;
      m_rd = 0;
      m_wd = 0;
      m_perr = 0;
      armed = 1;
    end else begin
      stall = m_starve == 4;
      ready = q.size() < 2;
      had = q.size() > 0;
      if (alu_valid && stall) m_perr = 1;
      if (alu_valid && !stall) begin
        m_we = alu_rd != 0;
        m_rd = alu_rd;
        m_wd = alu_data;
        m_starve = had ? m_starve + 1 : 0;
      end else if (had) begin
        e = q.pop_front();
        m_we = e.rd_addr != 0;
        m_rd = e.rd_addr;
        m_wd = e.w_data;
        m_starve = 0;
      end else begin
        m_we = 0;
        m_starve = 0;
      end
      if (lsu_valid && ready) q.push_back('{rd_addr: lsu_rd, w_data: lsu_data});
    end
  end
  always @(negedge clk) begin
    if (armed) begin
      chk("model_we", wEnable, m_we);
      chk("model_rd", rdAddr, m_rd);
      chk("model_wd", wData, m_wd);
      chk("model_ready", lsuReady, !rst && q.size() < 2);
      chk("model_stall", stallAlu, m_starve == 4);
      chk("model_perr", protoErr, m_perr);
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lr, input logic [31:0] ld);
    alu_valid = av;
    alu_rd = ar;
    alu_data = ad;
    lsu_valid = lv;
    lsu_rd = lr;
    lsu_data = ld;
  endtask
  task automatic starve_run(input logic [4:0] rd, input logic [31:0] d, output int n);
    drive(1, 5'd20, 32'h20, 1, rd, d);
    cyc();
    n = 0;
    for (int i = 0; i < 10 && !stallAlu; i++) begin
      drive(1, 5'(21 + i), 32'(i), 0, 0, 0);
      cyc();
      n++;
    end
  endtask
  initial begin
    int n;
    drive(1, 5'd9, 32'h99, 1, 5'd9, 32'h99);
    cyc();
    cyc();
    chk("rst_we", wEnable, 0);
    chk("rst_ready", lsuReady, 0);
    rst = 0;
    drive(0, 0, 0, 0, 0, 0);
    cyc();
    chk("post_rst_we", wEnable, 0);
    chk("post_rst_ready", lsuReady, 1);
    chk("post_rst_perr", protoErr, 0);
    drive(1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
    cyc();
    chk("alu_we", wEnable, 1);
    chk("alu_rd", rdAddr, 5);
    chk("alu_wd", wData, 32'hDEADBEEF);
    drive(1, 5'd0, 32'h1, 0, 0, 0);
    cyc();
    chk("alu_x0_we", wEnable, 0);
    drive(0, 0, 0, 1, 5'd7, 32'h1234);
    cyc();
    chk("lsu_n1_we", wEnable, 0);
    drive(0, 0, 0, 0, 0, 0);
    cyc();
    chk("lsu_n2_we", wEnable, 1);
    chk("lsu_n2_rd", rdAddr, 7);
    chk("lsu_n2_wd", wData, 32'h1234);
    drive(1, 5'd1, 32'h11, 1, 5'd10, 32'hA0);
    cyc();
    drive(1, 5'd2, 32'h22, 1, 5'd11, 32'hB0);
    cyc();
    chk("full_ready", lsuReady, 0);
    drive(1, 5'd3, 32'h33, 1, 5'd12, 32'hC0);
    cyc();
    chk("full_ready_held", lsuReady, 0);
    chk("busy_alu_rd", rdAddr, 3);
    drive(0, 0, 0, 0, 0, 0);
    cyc();
    chk("drain1_rd", rdAddr, 10);
    chk("drain1_wd", wData, 32'hA0);
    cyc();
    chk("drain2_rd", rdAddr, 11);
    cyc();
    chk("drain_idle_we", wEnable, 0);
    starve_run(5'd3, 32'h33, n);
    chk("starve_alu_writes", n, 4);
    chk("starve_stall", stallAlu, 1);
    drive(0, 0, 0, 0, 0, 0);
    cyc();
    chk("starve_pop_we", wEnable, 1);
    chk("starve_pop_rd", rdAddr, 3);
    chk("starve_pop_wd", wData, 32'h33);
    chk("starve_pulse", stallAlu, 0);
    cyc();
    starve_run(5'd4, 32'h44, n);
    chk("perr_alu_writes", n, 4);
    drive(1, 5'd25, 32'hBAD, 0, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    chk("perr_pop_rd", rdAddr, 4);
    chk("perr_pop_wd", wData, 32'h44);
    chk("perr_set", protoErr, 1);
    cyc();
    cyc();
    chk("perr_sticky", protoErr, 1);
    drive(1, 5'd1, 32'h11, 1, 5'd13, 32'hD0);
    cyc();
    drive(1, 5'd2, 32'h22, 1, 5'd14, 32'hE0);
    cyc();
    chk("mid_full", lsuReady, 0);
    rst = 1;
    drive(0, 0, 0, 0, 0, 0);
    cyc();
    chk("mid_rst_we", wEnable, 0);
    chk("mid_rst_perr", protoErr, 0);
    rst = 0;
    cyc();
    chk("mid_after_ready", lsuReady, 1);
    chk("mid_after_we", wEnable, 0);
    cyc();
    chk("mid_after_we2", wEnable, 0);
    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
